// File: rtl/pretrig_test_pulser_if.sv
// Control and hit-output bundle for the pre-trigger test pulser.
// The master drives the test controls. The slave (the pulser) returns the synthetic hits and frame status.
interface pretrig_test_pulser_if #(
    parameter int NUM_CH     = 16,
    parameter int SIZE_DELAY = 8
);
    logic                  test_enable;
    logic                  test_rate;
    logic                  test_overlay;
    logic [SIZE_DELAY-1:0] test_delay;
    logic [NUM_CH-1:0]     ch_mask;
    logic [NUM_CH-1:0]     test_hits;
    logic                  test_strobe;
    logic                  busy;
    logic [15:0]           frame_count;

    modport master (
        output test_enable, test_rate, test_overlay, test_delay, ch_mask,
        input  test_hits, test_strobe, busy, frame_count
    );

    modport slave (
        input  test_enable, test_rate, test_overlay, test_delay, ch_mask,
        output test_hits, test_strobe, busy, frame_count
    );
endinterface

// File: rtl/pretrig_test_pulser.sv
// Synthetic framed hit source for the pre-trigger test path: an A pulse, an optional delayed B pulse, and a frame strobe.
// Optional B-start jitter from a 16-bit LFSR is enabled by defining PRETRIG_TEST_JITTER_EN.
module pretrig_test_pulser #(
    parameter int NUM_CH      = 16,
    parameter int SIZE_DELAY  = 8,
    parameter int PULSE_WIDTH = 4,
    parameter int PERIOD_FAST = 300,
    parameter int PERIOD_SLOW = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    pretrig_test_pulser_if.slave   bus
);
`ifdef PRETRIG_TEST_JITTER_EN
    localparam int JITTER_MAX = 3;
`else
    localparam int JITTER_MAX = 0;
`endif
    localparam int MIN_PERIOD = (2 ** SIZE_DELAY) + PULSE_WIDTH + 1 + JITTER_MAX;
    localparam logic [15:0] LAST_FAST = 16'(PERIOD_FAST - 1);
    localparam logic [15:0] LAST_SLOW = 16'(PERIOD_SLOW - 1);
    localparam logic [15:0] PW_16     = 16'(PULSE_WIDTH);

    generate
        if ((PERIOD_FAST < MIN_PERIOD) || (PERIOD_SLOW < MIN_PERIOD) ||
            (PULSE_WIDTH < 1) || (PULSE_WIDTH > 15)) begin : g_param_check
            $error("pretrig_test_pulser: period or pulse width out of range");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_f;
    logic [15:0]           w_f_next;
    logic                  w_start;
    logic                  r_rate;
    logic                  r_overlay;
    logic [SIZE_DELAY-1:0] r_delay;
    logic [NUM_CH-1:0]     r_mask;
    logic                  w_rate_next;
    logic                  w_overlay_next;
    logic [SIZE_DELAY-1:0] w_delay_next;
    logic [NUM_CH-1:0]     w_mask_next;
    logic [1:0]            w_j_next;
    logic [15:0]           w_b_start;
    logic                  w_a;
    logic                  w_b;
    logic                  w_run;
    logic [15:0]           r_frame_count;
    logic [NUM_CH-1:0]     r_hits;
    logic                  r_strobe;
    logic                  r_busy;

`ifdef PRETRIG_TEST_JITTER_EN
    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;
    logic [1:0]  r_j;

    // Jitter source: advances once per frame start, and the new value supplies j for that frame.
    always_comb begin
        w_lfsr_next = r_lfsr;
        if (w_start) begin
            w_lfsr_next = lfsr_step(r_lfsr);
        end else begin
            w_lfsr_next = r_lfsr;
        end
        w_j_next = w_start ? w_lfsr_next[1:0] : r_j;
    end

    // LFSR state and the j value latched for the current frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
            r_j    <= 2'd0;
        end else begin
            r_lfsr <= w_lfsr_next;
            r_j    <= w_j_next;
        end
    end
`else
    assign w_j_next = 2'd0;
`endif

    // Next state, frame counter and frame-start latch selection.
    always_comb begin
        w_state_next = r_state;
        w_f_next     = r_f;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.test_enable) begin
                    w_state_next = RUN;
                    w_start      = 1'b1;
                    w_f_next     = 16'd0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (r_f == (r_rate ? LAST_FAST : LAST_SLOW)) begin
                    w_f_next = 16'd0;
                    if (bus.test_enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_f_next = r_f + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_f_next     = 16'd0;
            end
        endcase
        w_rate_next    = w_start ? bus.test_rate    : r_rate;
        w_overlay_next = w_start ? bus.test_overlay : r_overlay;
        w_delay_next   = w_start ? bus.test_delay   : r_delay;
        w_mask_next    = w_start ? bus.ch_mask      : r_mask;
    end

    // Pulse decode on the upcoming frame cycle, so the registered outputs line up with f.
    always_comb begin
        w_run     = (w_state_next == RUN);
        w_b_start = 16'(w_delay_next) + 16'(w_j_next);
        w_a       = (w_f_next < PW_16);
        w_b       = w_overlay_next && (w_f_next >= w_b_start) && (w_f_next < (w_b_start + PW_16));
    end

    // State, frame position, per-frame latches and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_f           <= 16'd0;
            r_rate        <= 1'b0;
            r_overlay     <= 1'b0;
            r_delay       <= {SIZE_DELAY{1'b0}};
            r_mask        <= {NUM_CH{1'b0}};
            r_frame_count <= 16'd0;
            r_hits        <= {NUM_CH{1'b0}};
            r_strobe      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_f           <= w_f_next;
            r_rate        <= w_rate_next;
            r_overlay     <= w_overlay_next;
            r_delay       <= w_delay_next;
            r_mask        <= w_mask_next;
            r_frame_count <= w_start ? (r_frame_count + 16'd1) : r_frame_count;
            r_hits        <= w_run ? (w_mask_next & {NUM_CH{w_a | w_b}}) : {NUM_CH{1'b0}};
            r_strobe      <= w_start;
            r_busy        <= w_run;
        end
    end

    assign bus.test_hits   = r_hits;
    assign bus.test_strobe = r_strobe;
    assign bus.busy        = r_busy;
    assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_pretrig_test_pulser.sv
// Directed bench for pretrig_test_pulser: reset, framing, overlay boundaries, mask, rate latching, stop and async reset.
module tb_pretrig_test_pulser;
    localparam int PW = 4;
    localparam int PF = 300;
    localparam int PS = 1000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pretrig_test_pulser_if #(.NUM_CH(16), .SIZE_DELAY(8)) bus ();

    pretrig_test_pulser #(
        .NUM_CH(16), .SIZE_DELAY(8), .PULSE_WIDTH(PW), .PERIOD_FAST(PF), .PERIOD_SLOW(PS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] fc_m;
    logic [15:0] lfsr_m;
    logic [1:0]  j_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference pattern {hits, strobe, busy} for frame cycle f.
    function automatic logic [17:0] exp_vec(int f, bit ov, int d, logic [15:0] m);
        bit a;
        bit b;
        a = (f < PW);
        b = ov && (f >= d + int'(j_m)) && (f < d + int'(j_m) + PW);
        return {((a || b) ? m : 16'h0000), (f == 0), 1'b1};
    endfunction

    // Step until the next strobe. The number of steps taken is returned, and frame_count is checked at the new frame.
    task automatic wait_start(output int steps);
        bit seen;
        seen  = 1'b0;
        steps = 0;
        while (!seen && steps < 1100) begin
            step();
            steps++;
            if (bus.test_strobe === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_start: no strobe within %0d cycles", steps);
        end else begin
            fc_m = fc_m + 16'd1;
`ifdef PRETRIG_TEST_JITTER_EN
            lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            j_m    = lfsr_m[1:0];
`endif
            n_cmp++;
            if (bus.frame_count !== fc_m) begin
                n_err++;
                $display("FAIL frame_count: got %h exp %h", bus.frame_count, fc_m);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            n_cmp++;
            if ({bus.test_hits, bus.test_strobe, bus.busy, bus.frame_count} !== 34'd0) begin
                n_err++;
                $display("FAIL reset_idle: cycle %0d hits %h strobe %b busy %b fc %h exp all 0",
                         i, bus.test_hits, bus.test_strobe, bus.busy, bus.frame_count);
            end
        end
    endtask

    task automatic test_fast_frames();
        int s;
        bus.test_rate = 1'b1; bus.test_overlay = 1'b0; bus.test_delay = 8'd0;
        bus.ch_mask = 16'h00F0; bus.test_enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_start(s);
            n_cmp++;
            if (s !== 1) begin
                n_err++;
                $display("FAIL fast_gap: frame %0d started after %0d steps exp 1", k, s);
            end
            for (int f = 0; f < PF; f++) begin
                if (f > 0) step();
                n_cmp++;
                if ({bus.test_hits, bus.test_strobe, bus.busy} !== exp_vec(f, 1'b0, 0, 16'h00F0)) begin
                    n_err++;
                    $display("FAIL fast f=%0d: got %h exp %h", f,
                             {bus.test_hits, bus.test_strobe, bus.busy}, exp_vec(f, 1'b0, 0, 16'h00F0));
                end
            end
        end
    endtask

    task automatic test_overlay(input int d, input int hit_cycles);
        int s;
        int n;
        n = 0;
        bus.test_overlay = 1'b1;
        bus.test_delay   = 8'(d);
        wait_start(s);
        for (int f = 0; f < PF; f++) begin
            if (f > 0) step();
            if (bus.test_hits !== 16'h0000) n++;
            n_cmp++;
            if ({bus.test_hits, bus.test_strobe, bus.busy} !== exp_vec(f, 1'b1, d, 16'h00F0)) begin
                n_err++;
                $display("FAIL overlay d=%0d f=%0d: got %h exp %h", d, f,
                         {bus.test_hits, bus.test_strobe, bus.busy}, exp_vec(f, 1'b1, d, 16'h00F0));
            end
        end
`ifndef PRETRIG_TEST_JITTER_EN
        n_cmp++;
        if (n !== hit_cycles) begin
            n_err++;
            $display("FAIL overlay_len d=%0d: got %0d hit cycles exp %0d", d, n, hit_cycles);
        end
`endif
    endtask

    task automatic test_mask_zero();
        int s;
        bus.ch_mask = 16'h0000; bus.test_delay = 8'd10;
        wait_start(s);
        for (int f = 0; f < PF; f++) begin
            if (f > 0) step();
            n_cmp++;
            if ({bus.test_hits, bus.test_strobe, bus.busy} !== {16'h0000, (f == 0), 1'b1}) begin
                n_err++;
                $display("FAIL mask_zero f=%0d: got %h", f, {bus.test_hits, bus.test_strobe, bus.busy});
            end
        end
    endtask

    // Rate changes mid-frame; the period must change only at the next frame, which is then slow and is stopped at f=100.
    task automatic test_rate_change_and_stop();
        int s;
        bus.ch_mask = 16'h00F0; bus.test_overlay = 1'b0; bus.test_rate = 1'b1;
        wait_start(s);
        for (int f = 1; f < PF; f++) begin
            step();
            if (f == 50) bus.test_rate = 1'b0;
        end
        wait_start(s);
        n_cmp++;
        if (s !== 1) begin
            n_err++;
            $display("FAIL rate_latch: next frame after %0d steps exp 1", s);
        end
        for (int f = 0; f < PS; f++) begin
            if (f > 0) step();
            if (f == 100) begin
                bus.test_enable = 1'b0;
                bus.test_rate   = 1'b1;
            end
            n_cmp++;
            if ({bus.test_hits, bus.test_strobe, bus.busy} !== exp_vec(f, 1'b0, 0, 16'h00F0)) begin
                n_err++;
                $display("FAIL slow_stop f=%0d: got %h exp %h", f,
                         {bus.test_hits, bus.test_strobe, bus.busy}, exp_vec(f, 1'b0, 0, 16'h00F0));
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({bus.test_hits, bus.test_strobe, bus.busy} !== 18'd0) begin
                n_err++;
                $display("FAIL after_stop cycle %0d: got %h exp 0", i, {bus.test_hits, bus.test_strobe, bus.busy});
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int s;
        bus.ch_mask = 16'hFFFF; bus.test_rate = 1'b1; bus.test_enable = 1'b1;
        wait_start(s);
        step();
        step();
        n_cmp++;
        if (bus.test_hits !== 16'hFFFF) begin
            n_err++;
            $display("FAIL mid_pulse_pre: got %h exp ffff", bus.test_hits);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.test_hits, bus.test_strobe, bus.busy, bus.frame_count} !== 34'd0) begin
            n_err++;
            $display("FAIL mid_pulse_reset: hits %h strobe %b busy %b fc %h exp all 0",
                     bus.test_hits, bus.test_strobe, bus.busy, bus.frame_count);
        end
        bus.test_enable = 1'b0;
        step();
        reset  = 1'b1;
        fc_m   = 16'd0;
        lfsr_m = 16'hACE1;
        j_m    = 2'd0;
        step();
        n_cmp++;
        if ({bus.test_hits, bus.busy, bus.frame_count} !== 33'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: hits %h busy %b fc %h exp all 0", bus.test_hits, bus.busy, bus.frame_count);
        end
    endtask

`ifdef PRETRIG_TEST_JITTER_EN
    task automatic test_jitter();
        int s;
        int b0;
        bus.ch_mask = 16'h0001; bus.test_rate = 1'b1; bus.test_overlay = 1'b1;
        bus.test_delay = 8'd20; bus.test_enable = 1'b1;
        for (int k = 0; k < 64; k++) begin
            wait_start(s);
            if (k == 63) bus.test_enable = 1'b0;
            b0 = -1;
            for (int f = 0; f < PF; f++) begin
                if (f > 0) step();
                if (f >= PW && b0 < 0 && bus.test_hits !== 16'h0000) b0 = f;
                n_cmp++;
                if ({bus.test_hits, bus.test_strobe, bus.busy} !== exp_vec(f, 1'b1, 20, 16'h0001)) begin
                    n_err++;
                    $display("FAIL jitter k=%0d f=%0d: got %h", k, f, {bus.test_hits, bus.test_strobe, bus.busy});
                end
            end
            n_cmp++;
            if (b0 !== 20 + int'(j_m)) begin
                n_err++;
                $display("FAIL jitter_start k=%0d: got %0d exp %0d", k, b0, 20 + int'(j_m));
            end
        end
    endtask
`endif

    initial begin
        fc_m   = 16'd0;
        lfsr_m = 16'hACE1;
        j_m    = 2'd0;
        bus.test_enable = 1'b0; bus.test_rate = 1'b0; bus.test_overlay = 1'b0;
        bus.test_delay  = 8'd0; bus.ch_mask   = 16'h0000;
        test_reset();
        test_fast_frames();
        test_overlay(2, 6);
        test_overlay(10, 8);
        test_overlay(0, 4);
        test_overlay(4, 8);
        test_overlay(255, 8);
        test_mask_zero();
        test_rate_change_and_stop();
        test_reset_mid_pulse();
`ifdef PRETRIG_TEST_JITTER_EN
        test_jitter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
